// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared definitions for the Cardinal pipeline hazard/stall
// controller.
//   state_t   - controller FSM states (RUN, MEM_WAIT, ERR)
//   REG_W     - register specifier width
//   NOP_INSTR - instruction word loaded into IF/ID when it is flushed
package cardinal_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Full-width specifier compare; r0 is an ordinary register here.
  function automatic logic spec_match(input logic [REG_W-1:0] a,
                                      input logic [REG_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/cardinal_hazard_cmp.sv
// cardinal_hazard_cmp: purely combinational register-specifier compare between
// the instruction in ID and the producer in EXMEM.
// Ports:
//   id_valid, id_rA, id_rB, id_rD       - ID instruction and its specifiers
//   id_uses_rA, id_uses_rB, id_is_branch - ID operand usage / branch flag
//   exmem_rD, exmem_wrEn                 - EXMEM destination and write enable
//   fwd_rA, fwd_rB                       - take the WB result for rA / rB
//   br_haz                               - branch in ID compares a register
//                                          still being produced in EXMEM
module cardinal_hazard_cmp
  import cardinal_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rA,
  input  logic [REG_W-1:0] id_rB,
  input  logic [REG_W-1:0] id_rD,
  input  logic             id_uses_rA,
  input  logic             id_uses_rB,
  input  logic             id_is_branch,
  input  logic [REG_W-1:0] exmem_rD,
  input  logic             exmem_wrEn,
  output logic             fwd_rA,
  output logic             fwd_rB,
  output logic             br_haz
);

  logic producer;

  assign producer = id_valid & exmem_wrEn;

  assign fwd_rA = producer & id_uses_rA   & spec_match(exmem_rD, id_rA);
  assign fwd_rB = producer & id_uses_rB   & spec_match(exmem_rD, id_rB);
  // Branches compare rD data in ID, which cannot be forwarded in time,
  // so this becomes a one-cycle stall instead.
  assign br_haz = producer & id_is_branch & spec_match(exmem_rD, id_rD);

endmodule

// File: rtl/cardinal_pipe_ctrl.sv
// cardinal_pipe_ctrl: pipeline hazard and stall controller for the Cardinal
// CMP core. Each cycle it decides whether PC, IF/ID and ID/EXMEM advance,
// hold or take a bubble, produces the operand-forward flags, freezes the pipe
// during an outstanding EXMEM memory/NIC access and flags a sticky timeout.
// Parameters:
//   MAX_WAIT - not-ready cycles tolerated in MEM_WAIT before timeout (1..65535)
//   CNT_W    - width of the saturating stall-cycle counter
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   id_*                        - ID-stage instruction information
//   exmem_rD/wrEn/memEn         - EXMEM-stage instruction information
//   dmem_ready                  - EXMEM memory access completes this cycle
//   pc_stall, ifid_stall        - hold PC / IF/ID
//   ifid_flush                  - load a NOP into IF/ID
//   idex_stall                  - hold ID/EXMEM
//   id_kill                     - bubble into ID/EXMEM
//   fwd_rA, fwd_rB              - forward WB result to EXMEM operands
//   mem_timeout                 - sticky memory-timeout error
//   stall_cycles                - saturating count of pc_stall cycles
module cardinal_pipe_ctrl
  import cardinal_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rA,
  input  logic [4:0]       id_rB,
  input  logic [4:0]       id_rD,
  input  logic             id_uses_rA,
  input  logic             id_uses_rB,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic [4:0]       exmem_rD,
  input  logic             exmem_wrEn,
  input  logic             exmem_memEn,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             id_kill,
  output logic             fwd_rA,
  output logic             fwd_rB,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_next;
  logic        br_haz;
  logic        mem_busy;
  logic        full_stall;
  logic        branch_flush;

  cardinal_hazard_cmp u_cmp (
    .id_valid     (id_valid),
    .id_rA        (id_rA),
    .id_rB        (id_rB),
    .id_rD        (id_rD),
    .id_uses_rA   (id_uses_rA),
    .id_uses_rB   (id_uses_rB),
    .id_is_branch (id_is_branch),
    .exmem_rD     (exmem_rD),
    .exmem_wrEn   (exmem_wrEn),
    .fwd_rA       (fwd_rA),
    .fwd_rB       (fwd_rB),
    .br_haz       (br_haz)
  );

  assign mem_busy     = exmem_memEn & ~dmem_ready;
  assign full_stall   = (state == ERR) | mem_busy;
  assign branch_flush = id_valid & id_is_branch & id_branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      mem_timeout <= (state_next == ERR);
    end
  end

  // wait_cnt counts the MEM_WAIT cycles of the current access; the RUN cycle
  // that detected the miss is cycle 1, so ERR follows MAX_WAIT+1 misses.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          state_next = MEM_WAIT;
          wait_next  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_next = ERR;
        end else begin
          wait_next = wait_cnt + 16'd1;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Memory freeze outranks the branch hazard, which outranks a taken-branch
  // flush: a branch held in ID must not squash the fetch behind it yet.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    idex_stall = 1'b0;
    id_kill    = 1'b0;
    ifid_flush = 1'b0;
    if (full_stall) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
    end else if (br_haz) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      id_kill    = 1'b1;
    end else if (branch_flush) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (pc_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cardinal_pipe_ctrl.sv
module tb_cardinal_pipe_ctrl;

  localparam int unsigned MW = 4;
  localparam int unsigned CW = 6;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rA, id_rB, id_rD;
  logic          id_uses_rA, id_uses_rB;
  logic          id_is_branch, id_branch_taken;
  logic [4:0]    exmem_rD;
  logic          exmem_wrEn, exmem_memEn;
  logic          dmem_ready;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, id_kill;
  logic          fwd_rA, fwd_rB;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles;
  logic [6:0]    outs;

  int n_cmp;
  int n_fail;

  // {pc_stall, ifid_stall, idex_stall, id_kill, ifid_flush, fwd_rA, fwd_rB}
  assign outs = {pc_stall, ifid_stall, idex_stall, id_kill, ifid_flush, fwd_rA, fwd_rB};

  cardinal_pipe_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rA           (id_rA),
    .id_rB           (id_rB),
    .id_rD           (id_rD),
    .id_uses_rA      (id_uses_rA),
    .id_uses_rB      (id_uses_rB),
    .id_is_branch    (id_is_branch),
    .id_branch_taken (id_branch_taken),
    .exmem_rD        (exmem_rD),
    .exmem_wrEn      (exmem_wrEn),
    .exmem_memEn     (exmem_memEn),
    .dmem_ready      (dmem_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_stall      (idex_stall),
    .id_kill         (id_kill),
    .fwd_rA          (fwd_rA),
    .fwd_rB          (fwd_rB),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rA = 0; id_rB = 0; id_rD = 0;
    id_uses_rA = 0; id_uses_rB = 0; id_is_branch = 0; id_branch_taken = 0;
    exmem_rD = 0; exmem_wrEn = 0; exmem_memEn = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    cyc();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", outs, 7'b0);
    end
    n_cmp++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %b want 0", mem_timeout);
    end
    n_cmp++;
    if (stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_forward();
    do_reset();
    id_valid = 1; id_uses_rA = 1; id_uses_rB = 1;
    id_rA = 3; id_rB = 4; exmem_rD = 3; exmem_wrEn = 1;
    #1;
    n_cmp++;
    if (outs !== 7'b0000010) begin
      n_fail++; $display("FAIL fwd_rA_hit: got %b want %b", outs, 7'b0000010);
    end
    exmem_wrEn = 0; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL fwd_no_wren: got %b want %b", outs, 7'b0);
    end
    exmem_wrEn = 1; id_rA = 5; id_rB = 3; #1;
    n_cmp++;
    if (outs !== 7'b0000001) begin
      n_fail++; $display("FAIL fwd_rB_hit: got %b want %b", outs, 7'b0000001);
    end
    id_uses_rB = 0; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL fwd_rB_unused: got %b want %b", outs, 7'b0);
    end
    id_rA = 0; id_rB = 0; exmem_rD = 0; id_uses_rB = 1; #1;
    n_cmp++;
    if (outs !== 7'b0000011) begin
      n_fail++; $display("FAIL fwd_r0: got %b want %b", outs, 7'b0000011);
    end
    id_valid = 0; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL fwd_invalid: got %b want %b", outs, 7'b0);
    end
    id_valid = 1; id_rA = 5'd19; exmem_rD = 5'd3; id_rB = 5'd2; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL fwd_msb_differs: got %b want %b", outs, 7'b0);
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    id_valid = 1; id_is_branch = 1; id_branch_taken = 1;
    id_rD = 7; exmem_rD = 7; exmem_wrEn = 1;
    #1;
    n_cmp++;
    if (outs !== 7'b1101000) begin
      n_fail++; $display("FAIL br_haz: got %b want %b", outs, 7'b1101000);
    end
    cyc();
    exmem_wrEn = 0;
    #1;
    n_cmp++;
    if (outs !== 7'b0000100) begin
      n_fail++; $display("FAIL br_taken_after_bubble: got %b want %b", outs, 7'b0000100);
    end
    n_cmp++;
    if (stall_cycles !== CW'(1)) begin
      n_fail++; $display("FAIL br_stall_count: got %0d want 1", stall_cycles);
    end
    exmem_wrEn = 1; exmem_rD = 5'd23; #1;
    n_cmp++;
    if (outs !== 7'b0000100) begin
      n_fail++; $display("FAIL br_msb_differs: got %b want %b", outs, 7'b0000100);
    end
    id_branch_taken = 0; exmem_rD = 5'd6; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL br_not_taken: got %b want %b", outs, 7'b0);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    exmem_memEn = 1; dmem_ready = 1; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL mem_ready_at_entry: got %b want %b", outs, 7'b0);
    end
    dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (outs !== 7'b1110000) begin
        n_fail++; $display("FAIL mem_stall_cycle%0d: got %b want %b", i, outs, 7'b1110000);
      end
      cyc();
    end
    // Fifth cycle sits at the wait limit: ready arriving now must win.
    dmem_ready = 1; #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL mem_ready_release: got %b want %b", outs, 7'b0);
    end
    cyc();
    exmem_memEn = 0; #1;
    n_cmp++;
    if (stall_cycles !== CW'(4)) begin
      n_fail++; $display("FAIL mem_stall_count: got %0d want 4", stall_cycles);
    end
    n_cmp++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mem_no_timeout: got %b want 0", mem_timeout);
    end
    // Back in RUN: a fresh access needs a full MW+1 misses to time out.
    exmem_memEn = 1; dmem_ready = 0;
    for (int i = 0; i < int'(MW); i++) cyc();
    n_cmp++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mem_rerun_early_timeout: got %b want 0", mem_timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_memEn = 1; dmem_ready = 0;
    for (int i = 0; i < int'(MW) + 1; i++) begin
      n_cmp++;
      if (mem_timeout !== 1'b0) begin
        n_fail++; $display("FAIL timeout_early_%0d: got %b want 0", i, mem_timeout);
      end
      cyc();
    end
    n_cmp++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_raised: got %b want 1", mem_timeout);
    end
    exmem_memEn = 0; dmem_ready = 1;
    id_valid = 1; id_is_branch = 1; id_branch_taken = 1;
    id_rD = 2; exmem_rD = 2; exmem_wrEn = 1;
    cyc(); cyc();
    n_cmp++;
    if (outs !== 7'b1110000) begin
      n_fail++; $display("FAIL err_stall_hold: got %b want %b", outs, 7'b1110000);
    end
    n_cmp++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b want 1", mem_timeout);
    end
    do_reset();
    n_cmp++;
    if ({mem_timeout, stall_cycles} !== {1'b0, CW'(0)}) begin
      n_fail++; $display("FAIL err_cleared_by_reset: got %b/%0d want 0/0", mem_timeout, stall_cycles);
    end
  endtask

  task automatic test_priority();
    do_reset();
    id_valid = 1; id_is_branch = 1; id_branch_taken = 1; id_uses_rA = 1;
    id_rA = 9; id_rD = 9; exmem_rD = 9; exmem_wrEn = 1;
    exmem_memEn = 1; dmem_ready = 0;
    #1;
    n_cmp++;
    if (outs !== 7'b1110010) begin
      n_fail++; $display("FAIL prio_mem_over_branch: got %b want %b", outs, 7'b1110010);
    end
    dmem_ready = 1; #1;
    n_cmp++;
    if (outs !== 7'b1101010) begin
      n_fail++; $display("FAIL prio_haz_over_taken: got %b want %b", outs, 7'b1101010);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    exmem_memEn = 1; dmem_ready = 0;
    cyc(); cyc();
    reset = 1;
    cyc();
    reset = 0;
    #1;
    n_cmp++;
    if (stall_cycles !== '0) begin
      n_fail++; $display("FAIL midwait_count_cleared: got %0d want 0", stall_cycles);
    end
    for (int i = 0; i < int'(MW) + 1; i++) begin
      n_cmp++;
      if (mem_timeout !== 1'b0) begin
        n_fail++; $display("FAIL midwait_early_timeout_%0d: got %b want 0", i, mem_timeout);
      end
      cyc();
    end
    n_cmp++;
    if ({mem_timeout, stall_cycles} !== {1'b1, CW'(MW + 1)}) begin
      n_fail++; $display("FAIL midwait_timeout: got %b/%0d want 1/%0d", mem_timeout, stall_cycles, MW + 1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    exmem_memEn = 1; dmem_ready = 0;
    for (int i = 0; i < int'(CNT_MAX); i++) cyc();
    n_cmp++;
    if (stall_cycles !== CW'(CNT_MAX)) begin
      n_fail++; $display("FAIL sat_reach: got %0d want %0d", stall_cycles, CNT_MAX);
    end
    for (int i = 0; i < 5; i++) cyc();
    n_cmp++;
    if (stall_cycles !== CW'(CNT_MAX)) begin
      n_fail++; $display("FAIL sat_hold: got %0d want %0d", stall_cycles, CNT_MAX);
    end
  endtask

  // Reference: an access fails once it has seen more than MW consecutive
  // not-ready cycles; the pipe freezes whenever the EXMEM access is missing
  // or the controller has failed.
  task automatic test_random();
    bit         m_err;
    int         m_misses;
    int         m_cnt;
    logic       busy, full, brh, tk, fa, fb;
    logic [6:0] exp_outs;
    do_reset();
    m_err = 0; m_misses = 0; m_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      reset           = ($urandom_range(79) == 0);
      id_valid        = ($urandom_range(4) != 0);
      id_rA           = 5'($urandom_range(3));
      id_rB           = 5'($urandom_range(3));
      id_rD           = 5'($urandom_range(3));
      id_uses_rA      = 1'($urandom_range(1));
      id_uses_rB      = 1'($urandom_range(1));
      id_is_branch    = ($urandom_range(2) == 0);
      id_branch_taken = 1'($urandom_range(1));
      exmem_rD        = 5'($urandom_range(3));
      exmem_wrEn      = 1'($urandom_range(1));
      exmem_memEn     = ($urandom_range(2) == 0);
      dmem_ready      = ($urandom_range(3) == 0) ? 1'b0 : 1'b1;
      if (m_misses > 0 && $urandom_range(1) == 0) dmem_ready = 0;
      #1;
      busy = exmem_memEn && !dmem_ready;
      full = m_err || busy;
      brh  = id_valid && id_is_branch && exmem_wrEn && (exmem_rD == id_rD);
      tk   = id_valid && id_is_branch && id_branch_taken;
      fa   = id_valid && id_uses_rA && exmem_wrEn && (exmem_rD == id_rA);
      fb   = id_valid && id_uses_rB && exmem_wrEn && (exmem_rD == id_rB);
      if (full)     exp_outs = {5'b11100, fa, fb};
      else if (brh) exp_outs = {5'b11010, fa, fb};
      else if (tk)  exp_outs = {5'b00001, fa, fb};
      else          exp_outs = {5'b00000, fa, fb};
      n_cmp++;
      if (outs !== exp_outs) begin
        n_fail++; $display("FAIL rand_outs@%0d: got %b want %b", c, outs, exp_outs);
      end
      n_cmp++;
      if ({mem_timeout, stall_cycles} !== {m_err, CW'(m_cnt)}) begin
        n_fail++; $display("FAIL rand_state@%0d: got %b/%0d want %b/%0d", c, mem_timeout, stall_cycles, m_err, m_cnt);
      end
      if (reset) begin
        m_err = 0; m_misses = 0; m_cnt = 0;
      end else begin
        if (exp_outs[6] && m_cnt < int'(CNT_MAX)) m_cnt++;
        if (!m_err) begin
          if (m_misses == 0) begin
            if (busy) m_misses = 1;
          end else if (dmem_ready) begin
            m_misses = 0;
          end else begin
            m_misses++;
            if (m_misses > int'(MW)) m_err = 1;
          end
        end
      end
      cyc();
    end
    reset = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1;
    set_idle();
    test_reset();
    test_forward();
    test_branch_hazard();
    test_mem_stall();
    test_timeout();
    test_priority();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cardinal_pipe_ctrl.md
# cardinal_pipe_ctrl

Pipeline hazard and stall controller for the Cardinal CMP core. It decides each cycle whether the PC, IF/ID and ID/EXMEM registers advance, hold or take a bubble. It generates the operand-forward flags that ride the ID/EXMEM register. It freezes the pipe while a data-memory or NIC access in EXMEM is outstanding, and raises a sticky error if that access never completes.

## Interface
Parameters:
- MAX_WAIT, 255, cycles an EXMEM memory access may stay not-ready before timeout; range 1..65535
- CNT_W, 32, width of the stall-cycle statistics counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rA, id_rB, id_rD  in  5 each  ID register specifiers; rD is read by branches and stores
- id_uses_rA, id_uses_rB  in  1 each  instruction reads that operand
- id_is_branch  in  1  ID instruction is a conditional branch (compares rD data in ID)
- id_branch_taken  in  1  branch resolved taken in ID; meaningful only when id_is_branch
- exmem_rD  in  5  destination of the EXMEM instruction
- exmem_wrEn, exmem_memEn  in  1 each  EXMEM control bits
- dmem_ready  in  1  data memory/NIC completes the EXMEM access this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  squash the IF/ID contents (load a NOP)
- idex_stall  out  1  drives the ID/EXMEM stall input
- id_kill  out  1  force wrEn/memEn/memwrEn entering ID/EXMEM to 0 (bubble)
- fwd_rA, fwd_rB  out  1 each  drive ID_forward_rA/rB
- mem_timeout  out  1  sticky error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

## Operation
- Register file is write-first, so WB→ID needs no forwarding. The only producer hazard is the EXMEM instruction, whose result reaches WB one cycle later.
- Every specifier compare uses all 5 bits. r0 gets no special case.
- fwd_rA = id_valid & id_uses_rA & exmem_wrEn & (exmem_rD == id_rA). fwd_rB is the same with rB. Both are combinational. EXMEM selects the WB result when the flag is set.
- br_haz = id_valid & id_is_branch & exmem_wrEn & (exmem_rD == id_rD). The branch is held in ID one cycle and a bubble goes to EXMEM. A second hazard cannot occur because the bubble has wrEn=0.
- mem_busy = exmem_memEn & !dmem_ready.
- FSM states RUN, MEM_WAIT, ERR.
  - RUN: if mem_busy, go to MEM_WAIT with wait_cnt <= 1; otherwise stay.
  - MEM_WAIT: if dmem_ready, go to RUN with wait_cnt <= 0. Else if wait_cnt == MAX_WAIT, go to ERR. Else wait_cnt + 1.
  - ERR: terminal until reset. mem_timeout = 1.
- Output priority, highest first:
  - ERR or mem_busy: pc_stall = ifid_stall = idex_stall = 1; id_kill = 0; ifid_flush = 0. Branch hazard and branch taken are ignored.
  - br_haz: pc_stall = ifid_stall = 1; idex_stall = 0; id_kill = 1; ifid_flush = 0.
  - id_valid & id_is_branch & id_branch_taken: ifid_flush = 1; all stalls 0.
  - Otherwise all 0.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones.

## Timing
- Reset values: state RUN, wait_cnt 0, mem_timeout 0, stall_cycles 0. Combinational outputs follow from the inputs, with state=RUN.
- All stall, flush, kill and forward outputs are combinational on the current-cycle inputs and state. They take effect at the next clk edge.
- A memory stall covers exactly the cycles with mem_busy=1. The cycle in which dmem_ready rises is not stalled.
- A branch hazard costs exactly 1 cycle. A taken branch costs 1 squashed fetch.
- When dmem_ready is already high on first entry, RUN does not transition and there is no stall.
- Timeout: ERR is entered at the edge after wait_cnt == MAX_WAIT with dmem_ready still 0, i.e. after MAX_WAIT+1 not-ready cycles. A ready arriving in that same cycle wins; go to RUN.
- Reset mid-wait drops to RUN the next edge and clears wait_cnt.
- mem_timeout is registered: it rises the cycle ERR is entered.

## Structure
- Shared package cardinal_pkg holds: the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2), REG_W=5 and the NOP encoding used by IF/ID flush.
- One sub-module, cardinal_hazard_cmp: the pure combinational specifier compare producing fwd_rA, fwd_rB and br_haz.
- The FSM, the wait counter and the stats counter live in the top module.

## Test plan
- ID uses rA=3, EXMEM rD=3, wrEn=1 -> fwd_rA=1, fwd_rB=0, no stalls. With wrEn=0 -> fwd_rA=0.
- ID branch with rD=7, EXMEM rD=7, wrEn=1 -> one cycle of pc/ifid stall and id_kill=1, idex_stall=0. The next cycle has no hazard; with taken=1, ifid_flush=1.
- exmem_memEn=1, dmem_ready low for 4 cycles then high -> all three stalls high exactly 4 cycles, stall_cycles=4, FSM back in RUN.
- MAX_WAIT=3, dmem_ready held 0 -> ERR after 4 not-ready cycles, mem_timeout=1, stalls stay high. After reset: mem_timeout=0, stall_cycles=0.
- mem_busy coinciding with br_haz and taken branch -> only full stall, id_kill=0, ifid_flush=0.
- Reset asserted during MEM_WAIT with wait_cnt=2 -> next cycle state RUN and wait_cnt=0. A new wait counts from 1.
